pc_stack_unit: RTL and testbench

Program-counter and return-address stack stage that feeds the instruction memory, whose 16-bit output goes to the control-unit decoder.
- Consumes the decoder's s_inc, s_pila, push and pop strobes, plus the 10-bit jump field opcode[9:0].
- Computes and registers the next fetch address.
- Maintains a hardware LIFO of return addresses, with full/empty status and sticky error flags.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/ret_stack.sv | 90 +++++++++
 rtl/pc_stack_unit.sv | 91 +++++++++
 tb/tb_pc_stack_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared PC/stack types and constants for the fetch-side pc_stack_unit.
// STACK_ERR_TRAP_EN (top-level build macro) enables trapping on stack errors.
package cpu_pkg;

  localparam int PC_W_DEFAULT      = 10;
  localparam int STK_DEPTH_DEFAULT = 16;

  typedef logic [PC_W_DEFAULT-1:0] pc_t;

  localparam pc_t RESET_PC            = '0;
  localparam pc_t TRAP_VECTOR_DEFAULT = 10'h3FF;

  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP,
    STK_SWAP
  } stk_op_e;

  function automatic stk_op_e stk_op(
    input logic push,
    input logic pop
  );
    stk_op_e op;
    op = STK_IDLE;
    unique case ({push, pop})
      2'b10:   op = STK_PUSH;
      2'b01:   op = STK_POP;
      2'b11:   op = STK_SWAP;
      default: op = STK_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: entry storage, occupancy counter, full/empty status
// and single-cycle overflow/underflow events for the enclosing PC stage.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = STK_DEPTH_DEFAULT,
  parameter int W     = PC_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_evt,
  output logic                     udf_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic [AW:0]   sp_nxt;
  logic          wr_en;
  stk_op_e       op;

  assign full    = (sp == FULL_CNT);
  assign empty   = (sp == '0);
  assign top_idx = AW'(sp - 1'b1);
  assign top     = empty ? '0 : mem[top_idx];
  assign op      = en ? stk_op(push, pop) : STK_IDLE;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    sp_nxt  = sp;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    unique case (op)
      STK_PUSH: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = sp[AW-1:0];
          sp_nxt = sp + 1'b1;
        end
      end
      STK_POP: begin
        if (empty) begin
          udf_evt = 1'b1;
        end else begin
          sp_nxt = sp - 1'b1;
        end
      end
      // Push+pop replaces the top; on an empty stack it degrades to a push.
      STK_SWAP: begin
        wr_en = 1'b1;
        if (empty) begin
          wr_idx = '0;
          sp_nxt = (AW+1)'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else begin
      sp <= sp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Fetch PC register, next-PC selection and sticky stack error flags.
// Build with STACK_ERR_TRAP_EN to redirect the PC to TRAP_VECTOR on errors.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEFAULT,
  parameter int              STK_DEPTH   = STK_DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] TRAP_VECTOR = PC_W'(TRAP_VECTOR_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       s_inc,
  input  logic                       s_pila,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            jump_addr,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            stack_top,
  output logic [$clog2(STK_DEPTH):0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stk_ovf,
  output logic                       stk_udf
);

`ifdef STACK_ERR_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic            ovf_evt;
  logic            udf_evt;
  logic            sel_stk;
  logic            sel_inc;
  logic            sel_jmp;

  assign pc_inc = pc + 1'b1;

  ret_stack #(
    .DEPTH (STK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .push    (push),
    .pop     (pop),
    .wdata   (pc_inc),
    .top     (stack_top),
    .sp      (sp),
    .full    (stack_full),
    .empty   (stack_empty),
    .ovf_evt (ovf_evt),
    .udf_evt (udf_evt)
  );

  // A return on an empty stack falls through to the next instruction.
  assign sel_stk = s_pila & ~stack_empty;
  assign sel_inc = ~sel_stk & (s_pila | s_inc);
  assign sel_jmp = ~s_pila & ~s_inc;

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      sel_stk: pc_nxt = stack_top;
      sel_inc: pc_nxt = pc_inc;
      sel_jmp: pc_nxt = jump_addr;
      default: pc_nxt = pc;
    endcase
    if (TRAP_ON && (ovf_evt || udf_evt)) begin
      pc_nxt = TRAP_VECTOR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= PC_W'(RESET_PC);
      stk_ovf <= 1'b0;
      stk_udf <= 1'b0;
    end else if (en) begin
      pc      <= pc_nxt;
      stk_ovf <= stk_ovf | ovf_evt;
      stk_udf <= stk_udf | udf_evt;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit against a queue-based stack model.
// Honors STACK_ERR_TRAP_EN the same way the design build does.
module tb_pc_stack_unit;

  localparam int DEPTH = 16;
  localparam int TRAP  = 'h3FF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       s_inc = 1'b0;
  logic       s_pila = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [9:0] jump_addr = '0;
  logic [9:0] pc;
  logic [9:0] stack_top;
  logic [4:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       stk_ovf;
  logic       stk_udf;

  int nvec = 0;
  int nerr = 0;

  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_udf;

  pc_stack_unit dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .s_inc       (s_inc),
    .s_pila      (s_pila),
    .push        (push),
    .pop         (pop),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .stack_top   (stack_top),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stk_ovf     (stk_ovf),
    .stk_udf     (stk_udf)
  );

  always #5 clk = ~clk;

  function automatic int m_top();
    return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
  endfunction

  task automatic m_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic m_step();
    int  inc;
    int  nxt;
    bit  emp;
    bit  ful;
    if (!en) return;
    inc = (m_pc + 1) % 1024;
    emp = (m_stk.size() == 0);
    ful = (m_stk.size() == DEPTH);
    if (s_pila && !emp) nxt = m_top();
    else if (s_pila || s_inc) nxt = inc;
    else nxt = int'(jump_addr);
`ifdef STACK_ERR_TRAP_EN
    if ((push && !pop && ful) || (pop && !push && emp)) nxt = TRAP;
`endif
    if (push && pop) begin
      if (emp) m_stk.push_back(inc);
      else m_stk[m_stk.size()-1] = inc;
    end else if (push) begin
      if (ful) m_ovf = 1'b1;
      else m_stk.push_back(inc);
    end else if (pop) begin
      if (emp) m_udf = 1'b1;
      else void'(m_stk.pop_back());
    end
    m_pc = nxt;
  endtask

  task automatic idle();
    en = 1'b1;
    s_inc = 1'b0;
    s_pila = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    jump_addr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
  endtask

  // Called 1 time unit after a rising edge; reset pulse ends well before the next.
  task automatic hw_reset();
    reset = 1'b0;
    m_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    en = 1'b0;
    #1 reset = 1'b0;
    m_reset();
    #1;
    nvec++;
    if (pc !== 10'h000) begin
      nerr++; $display("FAIL reset_pc: got %h want 000", pc);
    end
    nvec++;
    if (sp !== 5'd0) begin
      nerr++; $display("FAIL reset_sp: got %0d want 0", sp);
    end
    nvec++;
    if ({stack_empty, stack_full, stk_ovf, stk_udf} !== 4'b1000) begin
      nerr++; $display("FAIL reset_flags: got %b want 1000",
                       {stack_empty, stack_full, stk_ovf, stk_udf});
    end
    nvec++;
    if (stack_top !== 10'h000) begin
      nerr++; $display("FAIL reset_top: got %h want 000", stack_top);
    end
    reset = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_inc();
    hw_reset();
    idle();
    s_inc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      nvec++;
      if (pc !== 10'(i)) begin
        nerr++; $display("FAIL inc_pc%0d: got %h want %h", i, pc, 10'(i));
      end
      nvec++;
      if ({stack_empty, stk_ovf, stk_udf} !== 3'b100) begin
        nerr++; $display("FAIL inc_flags%0d: got %b want 100", i,
                         {stack_empty, stk_ovf, stk_udf});
      end
    end
  endtask

  task automatic test_call_ret();
    hw_reset();
    idle();
    s_inc = 1'b1;
    repeat (4) cyc();
    s_inc = 1'b0;
    push = 1'b1;
    jump_addr = 10'h100;
    cyc();
    nvec++;
    if (pc !== 10'h100 || sp !== 5'd1 || stack_top !== 10'h005) begin
      nerr++; $display("FAIL call: got pc=%h sp=%0d top=%h want 100/1/005",
                       pc, sp, stack_top);
    end
    push = 1'b0;
    s_pila = 1'b1;
    pop = 1'b1;
    cyc();
    nvec++;
    if (pc !== 10'h005 || sp !== 5'd0 || stack_empty !== 1'b1) begin
      nerr++; $display("FAIL ret: got pc=%h sp=%0d empty=%b want 005/0/1",
                       pc, sp, stack_empty);
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [9:0] want_pc;
`ifdef STACK_ERR_TRAP_EN
    want_pc = 10'h3FF;
`else
    want_pc = 10'h011;
`endif
    hw_reset();
    idle();
    s_inc = 1'b1;
    push = 1'b1;
    repeat (16) cyc();
    nvec++;
    if (sp !== 5'd16 || stack_full !== 1'b1 || stk_ovf !== 1'b0 || stack_top !== 10'h010) begin
      nerr++; $display("FAIL fill: got sp=%0d full=%b ovf=%b top=%h want 16/1/0/010",
                       sp, stack_full, stk_ovf, stack_top);
    end
    cyc();
    nvec++;
    if (sp !== 5'd16 || stack_full !== 1'b1 || stk_ovf !== 1'b1 || stack_top !== 10'h010) begin
      nerr++; $display("FAIL ovf: got sp=%0d full=%b ovf=%b top=%h want 16/1/1/010",
                       sp, stack_full, stk_ovf, stack_top);
    end
    nvec++;
    if (pc !== want_pc) begin
      nerr++; $display("FAIL ovf_pc: got %h want %h", pc, want_pc);
    end
    idle();
  endtask

  task automatic test_underflow();
    logic [9:0] want_pc;
`ifdef STACK_ERR_TRAP_EN
    want_pc = 10'h3FF;
`else
    want_pc = 10'h021;
`endif
    hw_reset();
    idle();
    jump_addr = 10'h020;
    cyc();
    nvec++;
    if (pc !== 10'h020) begin
      nerr++; $display("FAIL jump_pc: got %h want 020", pc);
    end
    s_pila = 1'b1;
    pop = 1'b1;
    cyc();
    nvec++;
    if (pc !== want_pc || sp !== 5'd0 || stk_udf !== 1'b1 || stk_ovf !== 1'b0) begin
      nerr++; $display("FAIL udf: got pc=%h sp=%0d udf=%b ovf=%b want %h/0/1/0",
                       pc, sp, stk_udf, stk_ovf, want_pc);
    end
    idle();
  endtask

  task automatic test_push_pop();
    hw_reset();
    idle();
    jump_addr = 10'h010;
    cyc();
    push = 1'b1; s_inc = 1'b1;
    cyc();
    push = 1'b0; s_inc = 1'b0; jump_addr = 10'h04F;
    cyc();
    push = 1'b1; s_inc = 1'b1;
    cyc();
    nvec++;
    if (sp !== 5'd2 || stack_top !== 10'h050) begin
      nerr++; $display("FAIL pp_setup: got sp=%0d top=%h want 2/050", sp, stack_top);
    end
    push = 1'b0; s_inc = 1'b0; jump_addr = 10'h0A0;
    cyc();
    push = 1'b1; pop = 1'b1; s_inc = 1'b1;
    cyc();
    nvec++;
    if (sp !== 5'd2 || stack_top !== 10'h0A1 || pc !== 10'h0A1) begin
      nerr++; $display("FAIL swap: got sp=%0d top=%h pc=%h want 2/0A1/0A1",
                       sp, stack_top, pc);
    end
    idle();
    jump_addr = 10'h3FF;
    cyc();
    s_inc = 1'b1;
    cyc();
    nvec++;
    if (pc !== 10'h000 || stk_ovf !== 1'b0) begin
      nerr++; $display("FAIL wrap: got pc=%h ovf=%b want 000/0", pc, stk_ovf);
    end
    idle();
  endtask

  task automatic test_async_reset();
    hw_reset();
    idle();
    s_inc = 1'b1;
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    push = 1'b1;
    repeat (3) cyc();
    push = 1'b0;
    nvec++;
    if (sp !== 5'd3 || stk_udf !== 1'b1) begin
      nerr++; $display("FAIL ar_setup: got sp=%0d udf=%b want 3/1", sp, stk_udf);
    end
    #2 reset = 1'b0;
    m_reset();
    #1;
    nvec++;
    if (pc !== 10'h000 || sp !== 5'd0 || stk_udf !== 1'b0 || stack_empty !== 1'b1) begin
      nerr++; $display("FAIL async_reset: got pc=%h sp=%0d udf=%b empty=%b want 000/0/0/1",
                       pc, sp, stk_udf, stack_empty);
    end
    #1 reset = 1'b1;
    idle();
  endtask

  task automatic test_enable();
    hw_reset();
    idle();
    s_inc = 1'b1;
    push = 1'b1;
    repeat (2) cyc();
    en = 1'b0;
    cyc();
    nvec++;
    if (pc !== 10'h002 || sp !== 5'd2) begin
      nerr++; $display("FAIL en_hold: got pc=%h sp=%0d want 002/2", pc, sp);
    end
    hw_reset();
    idle();
    en = 1'b0;
    pop = 1'b1;
    s_pila = 1'b1;
    cyc();
    nvec++;
    if (pc !== 10'h000 || sp !== 5'd0 || stk_udf !== 1'b0) begin
      nerr++; $display("FAIL en_noerr: got pc=%h sp=%0d udf=%b want 000/0/0",
                       pc, sp, stk_udf);
    end
    idle();
  endtask

  task automatic test_random();
    hw_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) hw_reset();
      en        = ($urandom_range(9) != 0);
      s_inc     = $urandom_range(1);
      s_pila    = ($urandom_range(3) == 0);
      push      = ($urandom_range(2) == 0);
      pop       = ($urandom_range(2) == 0);
      jump_addr = 10'($urandom);
      cyc();
      nvec++;
      if (pc !== 10'(m_pc)) begin
        nerr++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc, 10'(m_pc));
      end
      nvec++;
      if (sp !== 5'(m_stk.size()) || stack_top !== 10'(m_top())) begin
        nerr++; $display("FAIL rand_stk[%0d]: got sp=%0d top=%h want %0d/%h",
                         i, sp, stack_top, m_stk.size(), 10'(m_top()));
      end
      nvec++;
      if ({stack_full, stack_empty, stk_ovf, stk_udf} !==
          {m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_udf}) begin
        nerr++; $display("FAIL rand_flags[%0d]: got %b want %b", i,
                         {stack_full, stack_empty, stk_ovf, stk_udf},
                         {m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_udf});
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_inc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_async_reset();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
